// File: rtl/input_block_vc_credit_if.sv
// Link-side and allocator-side signal bundle of the credit-based router input block.
interface input_block_vc_credit_if #(
    parameter int unsigned PORT_NUM = 5,
    parameter int unsigned VC_NUM   = 4,
    parameter int unsigned FLIT_W   = 64
);
    localparam int unsigned VC_W = $clog2(VC_NUM);

    logic [PORT_NUM*FLIT_W-1:0]      data_i;
    logic [PORT_NUM-1:0]             valid_i;
    logic [PORT_NUM*VC_W-1:0]        vc_id_i;
    logic [PORT_NUM*VC_NUM-1:0]      vc_request_o;
    logic [PORT_NUM*VC_NUM*3-1:0]    out_port_o;
    logic [PORT_NUM*VC_NUM-1:0]      vc_valid_i;
    logic [PORT_NUM*VC_NUM*VC_W-1:0] vc_new_i;
    logic [PORT_NUM-1:0]             valid_sel_i;
    logic [PORT_NUM*VC_W-1:0]        vc_sel_i;
    logic [PORT_NUM*FLIT_W-1:0]      flit_o;
    logic [PORT_NUM*VC_W-1:0]        flit_vc_o;
    logic [PORT_NUM-1:0]             flit_valid_o;
    logic [PORT_NUM*VC_NUM-1:0]      credit_o;
    logic [PORT_NUM*VC_NUM-1:0]      is_full_o;
    logic [PORT_NUM*VC_NUM-1:0]      is_empty_o;
    logic [PORT_NUM*VC_NUM-1:0]      error_o;

    modport slave (
        input  data_i, valid_i, vc_id_i, vc_valid_i, vc_new_i, valid_sel_i, vc_sel_i,
        output vc_request_o, out_port_o, flit_o, flit_vc_o, flit_valid_o, credit_o,
               is_full_o, is_empty_o, error_o
    );

    modport master (
        output data_i, valid_i, vc_id_i, vc_valid_i, vc_new_i, valid_sel_i, vc_sel_i,
        input  vc_request_o, out_port_o, flit_o, flit_vc_o, flit_valid_o, credit_o,
               is_full_o, is_empty_o, error_o
    );
endinterface

// File: rtl/input_block_vc_credit.sv
// Router input block: per-port VC FIFOs, per-VC RC/VA/ACTIVE FSM, credit return.
// Optional macro ROUTE_YX_EN selects YX instead of XY dimension-order routing.
module input_block_vc_credit #(
    parameter int unsigned PORT_NUM    = 5,
    parameter int unsigned VC_NUM      = 4,
    parameter int unsigned BUFFER_SIZE = 8,
    parameter int unsigned FLIT_W      = 64,
    parameter int unsigned COORD_W     = 4,
    parameter int unsigned X_CURRENT   = 2,
    parameter int unsigned Y_CURRENT   = 2
) (
    input logic                    clk,
    input logic                    rst,
    input_block_vc_credit_if.slave bus
);
    localparam int unsigned VC_W  = $clog2(VC_NUM);
    localparam int unsigned PTR_W = $clog2(BUFFER_SIZE);
    localparam int unsigned CNT_W = $clog2(BUFFER_SIZE + 1);
    localparam int unsigned NVC   = PORT_NUM * VC_NUM;

    localparam logic [2:0] PORT_LOCAL = 3'd0;
    localparam logic [2:0] PORT_NORTH = 3'd1;
    localparam logic [2:0] PORT_SOUTH = 3'd2;
    localparam logic [2:0] PORT_WEST  = 3'd3;
    localparam logic [2:0] PORT_EAST  = 3'd4;

    localparam logic [COORD_W-1:0] X_CUR = COORD_W'(X_CURRENT);
    localparam logic [COORD_W-1:0] Y_CUR = COORD_W'(Y_CURRENT);

    typedef enum logic [1:0] {IDLE, VA, ACTIVE} vc_state_e;

    // Dimension-order route from the head flit's destination field.
    function automatic logic [2:0] route(input logic [2*COORD_W-1:0] dest);
        logic [COORD_W-1:0] dx;
        logic [COORD_W-1:0] dy;
        dx = dest[2*COORD_W-1:COORD_W];
        dy = dest[COORD_W-1:0];
`ifdef ROUTE_YX_EN
        if (dy > Y_CUR)      route = PORT_NORTH;
        else if (dy < Y_CUR) route = PORT_SOUTH;
        else if (dx > X_CUR) route = PORT_EAST;
        else if (dx < X_CUR) route = PORT_WEST;
        else                 route = PORT_LOCAL;
`else
        if (dx > X_CUR)      route = PORT_EAST;
        else if (dx < X_CUR) route = PORT_WEST;
        else if (dy > Y_CUR) route = PORT_NORTH;
        else if (dy < Y_CUR) route = PORT_SOUTH;
        else                 route = PORT_LOCAL;
`endif
    endfunction

    logic [NVC-1:0]               pop_ok;
    logic [NVC-1:0]               pop;
    logic [NVC-1:0]               vc_request;
    logic [NVC-1:0]               is_full;
    logic [NVC-1:0]               is_empty;
    logic [NVC-1:0]               error;
    logic [NVC*3-1:0]             out_port;
    logic [FLIT_W-1:0]            head_flit [PORT_NUM][VC_NUM];
    logic [VC_W-1:0]              vc_new    [PORT_NUM][VC_NUM];
    logic [PORT_NUM*FLIT_W-1:0]   flit;
    logic [PORT_NUM*VC_W-1:0]     flit_vc;
    logic [PORT_NUM-1:0]          flit_valid;
    logic [NVC-1:0]               credit;

    for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
        for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
            localparam int unsigned I = p * VC_NUM + v;

            logic [FLIT_W-1:0] mem_q [BUFFER_SIZE];
            logic [PTR_W-1:0]  rd_ptr_q;
            logic [PTR_W-1:0]  wr_ptr_q;
            logic [CNT_W-1:0]  count_q;
            vc_state_e         state_q, state_d;
            logic [2:0]        out_port_q, out_port_d;
            logic [VC_W-1:0]   vc_new_q, vc_new_d;
            logic              error_q;
            logic [FLIT_W-1:0] head;
            logic [1:0]        head_type;
            logic              empty, full, head_is_head, head_is_tail;
            logic              sel, push_req, discard, pop_ok_c, pop_c, push_c, err_c;

            assign head         = mem_q[rd_ptr_q];
            assign head_type    = head[FLIT_W-1 -: 2];
            assign head_is_head = (head_type == 2'b00) || (head_type == 2'b11);
            assign head_is_tail = head_type[1];
            assign empty        = (count_q == '0);
            assign full         = (count_q == CNT_W'(BUFFER_SIZE));
            assign sel          = bus.valid_sel_i[p] && (bus.vc_sel_i[p*VC_W +: VC_W] == VC_W'(v));
            assign push_req     = bus.valid_i[p] && (bus.vc_id_i[p*VC_W +: VC_W] == VC_W'(v));
            assign pop_ok_c     = sel && (state_q == ACTIVE) && !empty;
            assign discard      = (state_q == IDLE) && !empty && !head_is_head;
            assign pop_c        = pop_ok_c || discard;
            // A full FIFO still accepts a push when the same VC frees a slot this cycle.
            assign push_c       = push_req && (!full || pop_c);
            assign err_c        = (sel && !pop_ok_c) || discard || (push_req && !push_c);

            // Per-VC next-state: route compute in IDLE, wait for grant in VA, drain in ACTIVE.
            always_comb begin
                state_d    = state_q;
                out_port_d = out_port_q;
                vc_new_d   = vc_new_q;
                case (state_q)
                    IDLE: begin
                        if (!empty && head_is_head) begin
                            state_d    = VA;
                            out_port_d = route(head[2*COORD_W-1:0]);
                        end
                    end
                    VA: begin
                        if (bus.vc_valid_i[I]) begin
                            state_d  = ACTIVE;
                            vc_new_d = bus.vc_new_i[I*VC_W +: VC_W];
                        end
                    end
                    ACTIVE: begin
                        if (pop_ok_c && head_is_tail) state_d = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    state_q    <= IDLE;
                    out_port_q <= '0;
                    vc_new_q   <= '0;
                end else begin
                    state_q    <= state_d;
                    out_port_q <= out_port_d;
                    vc_new_q   <= vc_new_d;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    rd_ptr_q <= '0;
                    wr_ptr_q <= '0;
                    count_q  <= '0;
                    error_q  <= 1'b0;
                end else begin
                    if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                    if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                    count_q <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);
                    error_q <= error_q | err_c;
                end
            end

            always_ff @(posedge clk) begin
                if (push_c) mem_q[wr_ptr_q] <= bus.data_i[p*FLIT_W +: FLIT_W];
            end

            assign head_flit[p][v]      = head;
            assign vc_new[p][v]         = vc_new_q;
            assign pop_ok[I]            = pop_ok_c;
            // Discarded flits also free a slot, so they return a credit too.
            assign pop[I]               = pop_c;
            assign vc_request[I]        = (state_q == VA);
            assign is_full[I]           = full;
            assign is_empty[I]          = empty;
            assign error[I]             = error_q;
            assign out_port[I*3 +: 3]   = out_port_q;
        end

        logic [FLIT_W-1:0]  flit_q;
        logic [VC_W-1:0]    flit_vc_q;
        logic               flit_valid_q;
        logic [VC_NUM-1:0]  credit_q;
        logic [VC_W-1:0]    sel_vc;
        logic               any_pop;

        assign sel_vc  = bus.vc_sel_i[p*VC_W +: VC_W];
        assign any_pop = |pop_ok[p*VC_NUM +: VC_NUM];

        // Crossbar-side output register: flit and its credit leave together.
        always_ff @(posedge clk) begin
            if (!rst) begin
                flit_q       <= '0;
                flit_vc_q    <= '0;
                flit_valid_q <= 1'b0;
                credit_q     <= '0;
            end else begin
                flit_valid_q <= any_pop;
                credit_q     <= pop[p*VC_NUM +: VC_NUM];
                if (any_pop) begin
                    flit_q    <= head_flit[p][sel_vc];
                    flit_vc_q <= vc_new[p][sel_vc];
                end
            end
        end

        assign flit[p*FLIT_W +: FLIT_W]     = flit_q;
        assign flit_vc[p*VC_W +: VC_W]      = flit_vc_q;
        assign flit_valid[p]                = flit_valid_q;
        assign credit[p*VC_NUM +: VC_NUM]   = credit_q;
    end

    assign bus.vc_request_o = vc_request;
    assign bus.out_port_o   = out_port;
    assign bus.flit_o       = flit;
    assign bus.flit_vc_o    = flit_vc;
    assign bus.flit_valid_o = flit_valid;
    assign bus.credit_o     = credit;
    assign bus.is_full_o    = is_full;
    assign bus.is_empty_o   = is_empty;
    assign bus.error_o      = error;

endmodule
